// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg : shared AXI write-path constants and FSM state types
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axi_pkg;
    localparam logic [1:0] OKAY        = 2'b00;
    localparam logic [1:0] EXOKAY      = 2'b01;
    localparam logic [1:0] SLVERR      = 2'b10;
    localparam logic [1:0] DECERR      = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_8B     = 3'b011;

    // {len[2:0], id[3:0]} entry width of the burst-length FIFO
    localparam int         LEN_ID_W    = 7;

    typedef enum logic [0:0] {
        AW_IDLE = 1'b0,
        AW_SEND = 1'b1
    } aw_state_t;

    typedef enum logic [0:0] {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_t;
endpackage

`default_nettype wire

// File: rtl/axi_wr_master_if.sv
// ---------------------------------------------------------------------------
// axi_wr_master_if : AXI3 AW/W/B channel bundle with master/slave views
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface axi_wr_master_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [1:0]  AWBURST;
    logic [2:0]  AWSIZE;
    logic [3:0]  AWID;

    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic [3:0]  WID;

    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [3:0]  BID;

    modport master (
        output AWVALID, AWADDR, AWLEN, AWBURST, AWSIZE, AWID,
        output WVALID, WDATA, WSTRB, WLAST, WID,
        output BREADY,
        input  AWREADY, WREADY, BVALID, BRESP, BID
    );

    modport slave (
        input  AWVALID, AWADDR, AWLEN, AWBURST, AWSIZE, AWID,
        input  WVALID, WDATA, WSTRB, WLAST, WID,
        input  BREADY,
        output AWREADY, WREADY, BVALID, BRESP, BID
    );
endinterface

`default_nettype wire

// File: rtl/axi_wr_len_fifo.sv
// ---------------------------------------------------------------------------
// axi_wr_len_fifo : synchronous FIFO of {len, id} per accepted AW burst
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_wr_len_fifo
    import axi_pkg::*;
#(
    parameter int WIDTH = LEN_ID_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Extra pointer MSB separates the wrapped-full case from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];
endmodule

`default_nettype wire

// File: rtl/axi_wr_master.sv
// ---------------------------------------------------------------------------
// axi_wr_master : AXI3 write master turning commands + data beats into AW/W/B
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_wr_master
    import axi_pkg::*;
#(
    parameter int MAX_OUTST      = 4,
    parameter int LEN_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_len,
    input  logic        cmd_burst,
    input  logic [3:0]  cmd_id,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [63:0] wdata,
    axi_wr_master_if.master axi,
    output logic        done_valid,
    output logic [1:0]  done_resp,
    output logic [3:0]  done_id,
    output logic [7:0]  err_cnt,
    output logic [3:0]  outst_cnt
);
    aw_state_t             aw_state;
    aw_state_t             aw_state_nxt;
    w_state_t              w_state;
    w_state_t              w_state_nxt;
    logic                  accept;
    logic                  w_load;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  w_pop;
    logic                  b_hs;
    logic                  b_dec;
    logic                  bready_r;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LEN_ID_W-1:0]   fifo_head;
    logic [31:0]           aw_addr_r;
    logic [3:0]            aw_len_r;
    logic [1:0]            aw_burst_r;
    logic [3:0]            aw_id_r;
    logic [2:0]            w_len;
    logic [3:0]            w_id;
    logic [2:0]            beat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_state <= AW_IDLE;
            w_state  <= W_IDLE;
        end else begin
            aw_state <= aw_state_nxt;
            w_state  <= w_state_nxt;
        end
    end

    always_comb begin
        aw_state_nxt = aw_state;
        accept       = 1'b0;
        case (aw_state)
            AW_IDLE: begin
                if (cmd_valid && (outst_cnt < 4'(MAX_OUTST)) && !fifo_full) begin
                    accept       = 1'b1;
                    aw_state_nxt = AW_SEND;
                end
            end
            AW_SEND: begin
                if (axi.AWREADY) begin
                    aw_state_nxt = AW_IDLE;
                end
            end
            default: aw_state_nxt = AW_IDLE;
        endcase
    end

    always_comb begin
        w_state_nxt = w_state;
        w_load      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (!fifo_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = W_BURST;
                end
            end
            W_BURST: begin
                if (w_pop) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_hs  = axi.WVALID && axi.WREADY;
    assign w_pop = w_hs && axi.WLAST;
    assign b_hs  = axi.BVALID && bready_r;
    // A response with nothing outstanding must not underflow the counter
    assign b_dec = b_hs && (outst_cnt != 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready  <= 1'b0;
            aw_addr_r  <= '0;
            aw_len_r   <= '0;
            aw_burst_r <= BURST_FIXED;
            aw_id_r    <= '0;
        end else begin
            cmd_ready <= accept;
            if (accept) begin
                aw_addr_r  <= cmd_addr;
                aw_len_r   <= {1'b0, cmd_burst ? cmd_len : 3'd0};
                aw_burst_r <= cmd_burst ? BURST_INCR : BURST_FIXED;
                aw_id_r    <= cmd_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_len    <= '0;
            w_id     <= '0;
            beat_cnt <= '0;
        end else if (w_load) begin
            w_len    <= fifo_head[6:4];
            w_id     <= fifo_head[3:0];
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bready_r   <= 1'b0;
            outst_cnt  <= '0;
            err_cnt    <= '0;
            done_valid <= 1'b0;
            done_resp  <= OKAY;
            done_id    <= '0;
        end else begin
            bready_r   <= 1'b1;
            done_valid <= b_hs;
            if (b_hs) begin
                done_resp <= axi.BRESP;
                done_id   <= axi.BID;
            end
            case ({aw_hs, b_dec})
                2'b10:   outst_cnt <= outst_cnt + 4'd1;
                2'b01:   outst_cnt <= outst_cnt - 4'd1;
                default: outst_cnt <= outst_cnt;
            endcase
            if (b_hs && ((axi.BRESP != OKAY) || (outst_cnt == 4'd0)) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    axi_wr_len_fifo #(
        .WIDTH (LEN_ID_W),
        .DEPTH (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aw_hs),
        .push_data ({aw_len_r[2:0], aw_id_r}),
        .pop       (w_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign axi.AWVALID = (aw_state == AW_SEND);
    assign axi.AWADDR  = aw_addr_r;
    assign axi.AWLEN   = aw_len_r;
    assign axi.AWBURST = aw_burst_r;
    assign axi.AWSIZE  = SIZE_8B;
    assign axi.AWID    = aw_id_r;

    assign axi.WVALID  = (w_state == W_BURST) && wdata_valid;
    assign wdata_ready = (w_state == W_BURST) && axi.WREADY;
    assign axi.WDATA   = wdata;
    assign axi.WSTRB   = 8'hFF;
    assign axi.WLAST   = (w_state == W_BURST) && (beat_cnt == w_len);
    assign axi.WID     = w_id;

    assign axi.BREADY  = bready_r;
endmodule

`default_nettype wire

// File: tb/tb_axi_wr_master.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_master : directed table-driven bench with a reactive AXI slave
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_wr_master;
    import axi_pkg::*;

    typedef struct { logic [31:0] addr; logic [2:0] len; logic burst; logic [3:0] id; } cmd_t;
    typedef struct { logic [31:0] addr; logic [3:0] len; logic [1:0] burst; logic [2:0] size; logic [3:0] id; } aw_rec_t;
    typedef struct { logic [63:0] data; logic last; logic [3:0] id; logic [7:0] strb; } w_rec_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } d_rec_t;
    typedef struct {
        logic [31:0] addr; logic [2:0] len; logic burst; logic [3:0] id; logic [1:0] bresp;
        logic [3:0] e_awlen; logic [1:0] e_burst; int e_beats; logic [7:0] e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_len = '0;
    logic        cmd_burst = 1'b0;
    logic [3:0]  cmd_id = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [63:0] wdata = '0;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [3:0]  done_id;
    logic [7:0]  err_cnt;
    logic [3:0]  outst_cnt;

    axi_wr_master_if axi();

    axi_wr_master #(.MAX_OUTST(4), .LEN_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .axi(axi),
        .done_valid(done_valid), .done_resp(done_resp), .done_id(done_id),
        .err_cnt(err_cnt), .outst_cnt(outst_cnt)
    );

    always #5 clk = ~clk;

    cmd_t        cmd_q[$];
    logic [63:0] wq[$];
    logic [3:0]  bq[$];
    aw_rec_t     aw_log[$];
    w_rec_t      w_log[$];
    d_rec_t      done_log[$];

    logic        aw_ready_en = 1'b1;
    logic        w_ready_en = 1'b1;
    logic        b_en = 1'b1;
    logic [1:0]  b_resp_mode = OKAY;
    logic        force_b = 1'b0;
    logic [3:0]  force_id = '0;
    int          stall_at = -1;
    int          stall_left = 0;
    int          w_taken = 0;
    int          accept_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Requester + slave model: drives at each falling edge, records what will handshake at the next rising edge
    initial begin : slave_model
        logic       p_w, p_wlast, p_b, p_force;
        logic [3:0] p_wid;
        p_w = 0; p_wlast = 0; p_b = 0; p_force = 0; p_wid = 0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0; axi.BID = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_w = 0; p_b = 0; p_force = 0;
                cmd_valid = 0; wdata_valid = 0;
                axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0;
                continue;
            end
            if (p_w) begin
                w_taken++;
                if (wq.size() != 0) wq.delete(0);
                if (p_wlast) bq.push_back(p_wid);
            end
            if (p_b) begin
                if (p_force) force_b = 0;
                else if (bq.size() != 0) bq.delete(0);
            end
            if (cmd_ready && cmd_q.size() != 0) begin
                cmd_q.delete(0);
                accept_cnt++;
            end
            cmd_valid = (cmd_q.size() != 0);
            if (cmd_valid) begin
                cmd_addr = cmd_q[0].addr; cmd_len = cmd_q[0].len;
                cmd_burst = cmd_q[0].burst; cmd_id = cmd_q[0].id;
            end
            if (stall_left > 0 && w_taken == stall_at) begin
                wdata_valid = 0;
                stall_left--;
            end else begin
                wdata_valid = (wq.size() != 0);
            end
            wdata = (wq.size() != 0) ? wq[0] : 64'h0;
            axi.AWREADY = aw_ready_en;
            axi.WREADY  = w_ready_en;
            if (force_b) begin
                axi.BVALID = 1; axi.BID = force_id;
            end else if (b_en && bq.size() != 0) begin
                axi.BVALID = 1; axi.BID = bq[0];
            end else begin
                axi.BVALID = 0;
            end
            axi.BRESP = b_resp_mode;
            p_force = force_b;
            #1;
            if (axi.AWVALID && axi.AWREADY)
                aw_log.push_back('{axi.AWADDR, axi.AWLEN, axi.AWBURST, axi.AWSIZE, axi.AWID});
            p_w = axi.WVALID && axi.WREADY;
            if (p_w) begin
                w_log.push_back('{axi.WDATA, axi.WLAST, axi.WID, axi.WSTRB});
                p_wlast = axi.WLAST;
                p_wid   = axi.WID;
            end
            p_b = axi.BVALID && axi.BREADY;
            if (done_valid) done_log.push_back('{done_resp, done_id});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk("done_count", 64'(done_log.size()), 64'(n));
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [2:0] l, input logic b, input logic [3:0] i);
        cmd_t c;
        c.addr = a; c.len = l; c.burst = b; c.id = i;
        cmd_q.push_back(c);
    endtask

    task automatic clear_logs();
        aw_log.delete(); w_log.delete(); done_log.delete();
        w_taken = 0; accept_cnt = 0; stall_at = -1; stall_left = 0;
    endtask

    vec_t        vt[5];
    logic [63:0] ed[$];

    initial begin : main
        vt[0] = '{32'h0000_0100, 3'd0, 1'b0, 4'd3,  OKAY,   4'd0, BURST_FIXED, 1, 8'd0};
        vt[1] = '{32'h0000_2000, 3'd7, 1'b1, 4'd5,  OKAY,   4'd7, BURST_INCR,  8, 8'd0};
        vt[2] = '{32'h0000_0308, 3'd5, 1'b0, 4'd9,  EXOKAY, 4'd0, BURST_FIXED, 1, 8'd1};
        vt[3] = '{32'hFFF8_0000, 3'd3, 1'b1, 4'd15, DECERR, 4'd3, BURST_INCR,  4, 8'd2};
        vt[4] = '{32'h0000_0040, 3'd1, 1'b1, 4'd0,  OKAY,   4'd1, BURST_INCR,  2, 8'd2};

        #1 rst = 1'b0;
        cyc(3);
        chk("rst_cmd_ready", 64'(cmd_ready), 0);
        chk("rst_awvalid", 64'(axi.AWVALID), 0);
        chk("rst_wvalid", 64'(axi.WVALID), 0);
        chk("rst_done_valid", 64'(done_valid), 0);
        chk("rst_outst", 64'(outst_cnt), 0);
        chk("rst_err", 64'(err_cnt), 0);
        chk("rst_awaddr", 64'(axi.AWADDR), 0);
        chk("rst_awlen", 64'(axi.AWLEN), 0);
        chk("rst_awid", 64'(axi.AWID), 0);
        rst = 1'b1;
        cyc(2);
        chk("bready_after_rst", 64'(axi.BREADY), 1);

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            ed.delete();
            b_resp_mode = vt[v].bresp;
            for (int b = 0; b < vt[v].e_beats; b++) begin
                ed.push_back({vt[v].addr, 24'hA5A5A5, 4'(b), vt[v].id});
                wq.push_back({vt[v].addr, 24'hA5A5A5, 4'(b), vt[v].id});
            end
            push_cmd(vt[v].addr, vt[v].len, vt[v].burst, vt[v].id);
            wait_done(1, 100);
            cyc(2);
            chk("vec_aw_count", 64'(aw_log.size()), 1);
            if (aw_log.size() == 1) begin
                chk("vec_awaddr", 64'(aw_log[0].addr), 64'(vt[v].addr));
                chk("vec_awlen", 64'(aw_log[0].len), 64'(vt[v].e_awlen));
                chk("vec_awburst", 64'(aw_log[0].burst), 64'(vt[v].e_burst));
                chk("vec_awsize", 64'(aw_log[0].size), 64'(3'b011));
                chk("vec_awid", 64'(aw_log[0].id), 64'(vt[v].id));
            end
            chk("vec_beats", 64'(w_log.size()), 64'(vt[v].e_beats));
            for (int b = 0; b < w_log.size() && b < vt[v].e_beats; b++) begin
                chk("vec_wdata", w_log[b].data, ed[b]);
                chk("vec_wlast", 64'(w_log[b].last), 64'(b == vt[v].e_beats - 1));
                chk("vec_wid", 64'(w_log[b].id), 64'(vt[v].id));
                chk("vec_wstrb", 64'(w_log[b].strb), 64'hFF);
            end
            if (done_log.size() != 0) begin
                chk("vec_done_id", 64'(done_log[0].id), 64'(vt[v].id));
                chk("vec_done_resp", 64'(done_log[0].resp), 64'(vt[v].bresp));
            end
            chk("vec_err_cnt", 64'(err_cnt), 64'(vt[v].e_err));
            chk("vec_outst", 64'(outst_cnt), 0);
        end

        // INCR-8 with a 3-cycle data gap after the third beat
        clear_logs();
        ed.delete();
        b_resp_mode = OKAY;
        stall_at = 3; stall_left = 3;
        for (int b = 0; b < 8; b++) begin
            ed.push_back(64'hC0DE_0000_0000_0000 | 64'(b * 17));
            wq.push_back(64'hC0DE_0000_0000_0000 | 64'(b * 17));
        end
        push_cmd(32'h0000_1000, 3'd7, 1'b1, 4'd6);
        wait_done(1, 100);
        cyc(2);
        chk("stall_beats", 64'(w_log.size()), 8);
        for (int b = 0; b < w_log.size() && b < 8; b++) begin
            chk("stall_wdata", w_log[b].data, ed[b]);
            chk("stall_wlast", 64'(w_log[b].last), 64'(b == 7));
        end

        // Outstanding limit with B withheld
        clear_logs();
        b_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wq.push_back(64'hBEEF_0000 + 64'(i));
            push_cmd(32'(i * 8), 3'd0, 1'b0, 4'(i + 1));
        end
        cyc(60);
        chk("outst_aw_count", 64'(aw_log.size()), 4);
        chk("outst_cnt_full", 64'(outst_cnt), 4);
        chk("outst_accepts", 64'(accept_cnt), 4);
        chk("outst_cmd_ready", 64'(cmd_ready), 0);
        chk("outst_w_drained", 64'(w_log.size()), 4);
        b_en = 1'b1;
        wait_done(6, 200);
        cyc(2);
        chk("outst_aw_final", 64'(aw_log.size()), 6);
        chk("outst_cnt_final", 64'(outst_cnt), 0);
        for (int i = 0; i < done_log.size() && i < 6; i++)
            chk("outst_done_id", 64'(done_log[i].id), 64'(i + 1));

        // Same-cycle AW and B handshakes
        clear_logs();
        b_en = 1'b0;
        wq.push_back(64'h7777);
        push_cmd(32'h700, 3'd0, 1'b0, 4'd7);
        cyc(15);
        chk("simul_pre_outst", 64'(outst_cnt), 1);
        aw_ready_en = 1'b0;
        wq.push_back(64'h8888);
        push_cmd(32'h800, 3'd0, 1'b0, 4'd8);
        cyc(5);
        chk("simul_awvalid_held", 64'(axi.AWVALID), 1);
        chk("simul_aw_count", 64'(aw_log.size()), 1);
        aw_ready_en = 1'b1;
        b_en = 1'b1;
        cyc(1);
        chk("simul_both_hs_pending", 64'({axi.AWVALID, axi.AWREADY, axi.BVALID}), 64'b111);
        cyc(1);
        chk("simul_outst_same", 64'(outst_cnt), 1);
        wait_done(2, 100);
        cyc(2);
        chk("simul_outst_end", 64'(outst_cnt), 0);
        chk("simul_err", 64'(err_cnt), 2);

        // Stray B with nothing outstanding
        clear_logs();
        force_id = 4'hC;
        force_b = 1'b1;
        wait_done(1, 20);
        cyc(1);
        if (done_log.size() != 0) chk("stray_done_id", 64'(done_log[0].id), 64'hC);
        chk("stray_outst", 64'(outst_cnt), 0);
        chk("stray_err", 64'(err_cnt), 3);

        // 300 SLVERR responses saturate the error counter
        clear_logs();
        b_resp_mode = SLVERR;
        for (int i = 0; i < 300; i++) begin
            wq.push_back(64'(i));
            push_cmd(32'(i * 8), 3'd0, 1'b0, 4'(i));
        end
        wait_done(300, 5000);
        cyc(2);
        chk("sat_err_cnt", 64'(err_cnt), 64'hFF);
        chk("sat_outst", 64'(outst_cnt), 0);
        if (done_log.size() == 300) chk("sat_last_resp", 64'(done_log[299].resp), 64'(SLVERR));

        // Reset asserted in the middle of an INCR-8 burst
        clear_logs();
        b_resp_mode = OKAY;
        for (int b = 0; b < 8; b++) wq.push_back(64'hD00D_0000 + 64'(b));
        push_cmd(32'h0000_3000, 3'd7, 1'b1, 4'd2);
        begin
            int k = 0;
            while (w_log.size() < 3 && k < 50) begin
                cyc(1);
                k++;
            end
        end
        chk("rstmid_beats_seen", 64'(w_log.size() >= 3), 1);
        rst = 1'b0;
        #1;
        chk("rstmid_awvalid", 64'(axi.AWVALID), 0);
        chk("rstmid_wvalid", 64'(axi.WVALID), 0);
        chk("rstmid_cmd_ready", 64'(cmd_ready), 0);
        chk("rstmid_done_valid", 64'(done_valid), 0);
        chk("rstmid_outst", 64'(outst_cnt), 0);
        chk("rstmid_err", 64'(err_cnt), 0);
        cmd_q.delete(); wq.delete(); bq.delete();
        cyc(2);
        clear_logs();
        rst = 1'b1;
        cyc(2);
        wq.push_back(64'h1234_5678_9ABC_DEF0);
        push_cmd(32'h0000_0080, 3'd0, 1'b0, 4'd9);
        wait_done(1, 100);
        cyc(2);
        chk("post_rst_beats", 64'(w_log.size()), 1);
        if (w_log.size() == 1) begin
            chk("post_rst_wdata", w_log[0].data, 64'h1234_5678_9ABC_DEF0);
            chk("post_rst_wlast", 64'(w_log[0].last), 1);
        end
        if (done_log.size() != 0) begin
            chk("post_rst_done_id", 64'(done_log[0].id), 9);
            chk("post_rst_done_resp", 64'(done_log[0].resp), 0);
        end
        chk("post_rst_err", 64'(err_cnt), 0);
        chk("post_rst_outst", 64'(outst_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/axi_wr_master.md
Name: axi_wr_master

Overview:
- AXI3-style write master that turns simple write commands plus a 64-bit data stream into AW/W/B channel traffic.
- Sits directly upstream of the write-side AXI slave: drives its AW and W channels and consumes its B responses.
- Tracks outstanding transactions and reports per-transaction completion status to the local requester (DMA/test engine).

Parameters:
MAX_OUTST, 4, maximum AW handshakes awaiting B response (1..15)
LEN_FIFO_DEPTH, 4, entries in internal burst-length FIFO (power of 2, >= MAX_OUTST)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  write command available
cmd_ready  out  1  command accepted this cycle
cmd_addr  in  32  start byte address (8-byte aligned)
cmd_len  in  3  beats minus one (0..7)
cmd_burst  in  1  1=INCR burst, 0=single beat
cmd_id  in  4  transaction ID
wdata_valid  in  1  write data beat available
wdata_ready  out  1  beat consumed
wdata  in  64  write data beat
AWVALID/AWREADY  out/in  1/1  AW handshake
AWADDR  out  32  address
AWLEN  out  4  beats minus one
AWBURST  out  2  00 FIXED, 01 INCR
AWSIZE  out  3  fixed 3'b011 (8 bytes)
AWID  out  4  ID
WVALID/WREADY  out/in  1/1  W handshake
WDATA  out  64  data
WSTRB  out  8  fixed 8'hFF
WLAST  out  1  last beat of burst
WID  out  4  ID of current burst
BVALID/BREADY  in/out  1/1  B handshake
BRESP  in  2  response
BID  in  4  response ID
done_valid  out  1  one-cycle completion pulse
done_resp  out  2  BRESP of completed transaction
done_id  out  4  BID of completed transaction
err_cnt  out  8  count of non-OKAY responses, saturating
outst_cnt  out  4  current outstanding count

Behaviour:
- Reset (rst=0, async): AWVALID, WVALID, cmd_ready, done_valid = 0; outst_cnt, err_cnt = 0; AWADDR/AWLEN/AWID = 0; FSMs go to IDLE; len FIFO empty. In-flight transactions are dropped with no completion.
- AW FSM: states AW_IDLE and AW_SEND.
  - AW_IDLE: if cmd_valid && outst_cnt < MAX_OUTST && !len_fifo_full, then cmd_ready = 1 for exactly one cycle (registered), capture the command, and go to AW_SEND next cycle with AWVALID = 1.
  - AW payload: AWLEN = {1'b0, cmd_burst ? cmd_len : 3'b0}; AWBURST = cmd_burst ? 01 : 00.
  - AW_SEND: hold AWVALID and the payload stable until AWREADY. On handshake, push {AWLEN[2:0], AWID} to the len FIFO, increment outst_cnt, and return to AW_IDLE.
  - Minimum 2 cycles between command accepts.
- W FSM: states W_IDLE and W_BURST.
  - W_IDLE: if the len FIFO is non-empty, load len/id from the head, clear beat_cnt, and go to W_BURST. W never precedes its AW handshake.
  - W_BURST: WVALID = wdata_valid; wdata_ready = WREADY (combinational pass-through); WDATA = wdata; WID = loaded id; WLAST = (beat_cnt == len).
  - Each handshake increments beat_cnt (3-bit).
  - On the WLAST handshake, pop the FIFO and return to W_IDLE, giving a one-cycle bubble between bursts.
  - Outside W_BURST: WVALID = 0, wdata_ready = 0.
- B channel: BREADY = 1 whenever out of reset.
  - On BVALID && BREADY, decrement outst_cnt.
  - The following cycle: done_valid = 1, done_resp = BRESP, done_id = BID.
  - If BRESP != OKAY, err_cnt increments, saturating at 8'hFF.
- outst_cnt arithmetic: AW handshake and B handshake in the same cycle leave it unchanged. A B handshake with outst_cnt == 0 is a protocol error: ignore the decrement (stay 0), still pulse done_valid, and increment err_cnt.
- Back-pressure: wdata_valid low mid-burst stalls WVALID with no beat loss. AWREADY held low leaves AWVALID asserted indefinitely; W continues to drain previously accepted bursts.
- Full: when outst_cnt == MAX_OUTST or the FIFO is full, cmd_ready stays 0.

Decomposition:
- Shared package axi_pkg: OKAY/EXOKAY/SLVERR/DECERR, BURST_FIXED/BURST_INCR, SIZE_8B constants, aw_state_t and w_state_t enums.
- Sub-module axi_wr_len_fifo: synchronous FIFO, width 7 ({len, id}), depth LEN_FIFO_DEPTH, with push/pop/full/empty and head data visible combinationally.

Test Plan:
- Single beat: cmd addr=0x100, burst=0, id=3, AWREADY=1, WREADY=1, BRESP=00 -> AWLEN=0, AWBURST=00, one W beat with WLAST=1, WID=3; done_valid pulse with done_id=3, done_resp=00; err_cnt=0.
- INCR burst: len=7 -> AWLEN=7, AWBURST=01; exactly 8 W beats, WLAST only on the 8th; wdata_valid dropped for 3 cycles mid-burst -> no beat lost, data order preserved.
- Outstanding limit: MAX_OUTST=4, BVALID held 0, 6 commands queued -> exactly 4 AW handshakes, cmd_ready stays 0, outst_cnt=4; release B -> remaining 2 issue.
- Errors: BRESP=10 on 300 transactions -> err_cnt saturates at 0xFF; simultaneous AW and B handshake -> outst_cnt unchanged.
- Reset mid-burst: rst low during beat 3 of 8 -> all valids 0 and counters 0 immediately; after release, a new single-beat command completes normally.
